// File: rtl/result_reader_pkg.sv
// Shared definitions for the result read-out block: FSM encodings and
// address-map helpers used to size and locate the result matrix in data memory.
package result_reader_pkg;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RD   = 3'd1;
    localparam logic [2:0] S_CAP  = 3'd2;
    localparam logic [2:0] S_SEND = 3'd3;
    localparam logic [2:0] S_FIN  = 3'd4;

    function automatic int rr_clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

    // Result matrix sits after matrix1 (M*N words) and matrix2 (N*N2 words).
    function automatic int rr_base(input int m, input int n, input int n2);
        return m * n + n * n2;
    endfunction

endpackage

// File: rtl/result_reader.sv
// Streams the M x N2 result matrix out of CPU data memory once the program
// signals done, latching the CPU performance counters and a running checksum.
module result_reader
    import result_reader_pkg::*;
#(
    parameter int M  = 100,
    parameter int N  = 50,
    parameter int N2 = 2,
    parameter int W  = 32,
    parameter int AW = rr_clog2(M * N + N * N2 + M * N2)
) (
    input  logic          CLOCK_50,
    input  logic          rst,
    input  logic          done,
    input  logic [31:0]   clock_count,
    input  logic [31:0]   instr_cnt,
    output logic          mem_rd_en,
    output logic [AW-1:0] mem_addr,
    input  logic [W-1:0]  mem_rdata,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_data,
    output logic          out_last,
    output logic [W-1:0]  checksum,
    output logic [31:0]   cycles_lat,
    output logic [31:0]   instrs_lat,
    output logic          busy,
    output logic          finished,
    output logic [9:0]    LEDR
);

    localparam logic [AW-1:0] BASE_A = AW'(rr_base(M, N, N2));
    localparam logic [AW-1:0] LAST_A = AW'(M * N2 - 1);

    logic [2:0]    state;
    logic [AW-1:0] idx;
    logic          done_q;
    logic          trigger;

    // done_q resets high so a done level present at reset release is not an edge.
    assign trigger = done && !done_q;

    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            state      <= S_IDLE;
            idx        <= '0;
            done_q     <= 1'b1;
            out_data   <= '0;
            checksum   <= '0;
            cycles_lat <= '0;
            instrs_lat <= '0;
        end else begin
            done_q <= done;
            case (state)
                S_IDLE: begin
                    if (trigger) begin
                        cycles_lat <= clock_count;
                        instrs_lat <= instr_cnt;
                        checksum   <= '0;
                        idx        <= '0;
                        state      <= S_RD;
                    end
                end
                S_RD: state <= S_CAP;
                // Memory returns data one cycle after the strobe issued in RD.
                S_CAP: begin
                    out_data <= mem_rdata;
                    state    <= S_SEND;
                end
                S_SEND: begin
                    if (out_ready) begin
                        checksum <= checksum + out_data;
                        if (idx == LAST_A) begin
                            state <= S_FIN;
                        end else begin
                            idx   <= idx + AW'(1);
                            state <= S_RD;
                        end
                    end
                end
                S_FIN: state <= S_FIN;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign mem_rd_en = (state == S_RD);
    assign mem_addr  = mem_rd_en ? (BASE_A + idx) : '0;
    assign out_valid = (state == S_SEND);
    assign out_last  = out_valid && (idx == LAST_A);
    assign busy      = (state == S_RD) || (state == S_CAP) || (state == S_SEND);
    assign finished  = (state == S_FIN);
    assign LEDR      = checksum[9:0];

endmodule

// File: tb/tb_result_reader.sv
// Directed bench for result_reader with a 2x2x2 configuration (result words at 8..11).
module tb_result_reader;

    localparam int M  = 2;
    localparam int N  = 2;
    localparam int N2 = 2;
    localparam int W  = 32;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          done;
    logic [31:0]   clock_count;
    logic [31:0]   instr_cnt;
    logic          mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic [W-1:0]  mem_rdata;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic          out_last;
    logic [W-1:0]  checksum;
    logic [31:0]   cycles_lat;
    logic [31:0]   instrs_lat;
    logic          busy;
    logic          finished;
    logic [9:0]    LEDR;

    logic [W-1:0]  mem [0:15];
    logic [W-1:0]  exp_q [$];
    logic [31:0]   rd_q [$];
    int            total = 0;
    int            bad   = 0;

    result_reader #(.M(M), .N(N), .N2(N2), .W(W)) dut (
        .CLOCK_50   (clk),
        .rst        (rst),
        .done       (done),
        .clock_count(clock_count),
        .instr_cnt  (instr_cnt),
        .mem_rd_en  (mem_rd_en),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .checksum   (checksum),
        .cycles_lat (cycles_lat),
        .instrs_lat (instrs_lat),
        .busy       (busy),
        .finished   (finished),
        .LEDR       (LEDR)
    );

    always #5 clk = ~clk;

    // Synchronous data memory: one-cycle read latency.
    always @(posedge clk) begin
        if (mem_rd_en) mem_rdata <= mem[mem_addr];
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load_results(input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] c, input logic [31:0] d);
        mem[8] = a; mem[9] = b; mem[10] = c; mem[11] = d;
        exp_q.delete();
        exp_q.push_back(a); exp_q.push_back(b); exp_q.push_back(c); exp_q.push_back(d);
        rd_q.delete();
    endtask

    task automatic do_reset;
        rst = 1'b1;
        tick;
        rst = 1'b0;
    endtask

    // Collect nwords handshakes, optionally withholding out_ready for stall_len
    // cycles on word stall_idx, checking each word against the scoreboard.
    task automatic collect(input int stall_idx, input int stall_len, input int nwords);
        int got;
        int guard;
        int stalled;
        logic [W-1:0] exp;
        got = 0; guard = 0; stalled = 0;
        while (got < nwords && guard < 300) begin
            guard++;
            if (mem_rd_en) rd_q.push_back(32'(mem_addr));
            if (out_valid) begin
                if (got == stall_idx && stalled < stall_len) begin
                    out_ready = 1'b0;
                    check("stall_valid", 32'(out_valid), 32'd1);
                    check("stall_data", out_data, exp_q.size() > 0 ? exp_q[0] : 32'hDEADBEEF);
                    check("stall_no_rd", 32'(mem_rd_en), 32'd0);
                    stalled++;
                end else begin
                    out_ready = 1'b1;
                    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEADBEEF;
                    check("word", out_data, exp);
                    check("last", 32'(out_last), (got == 3) ? 32'd1 : 32'd0);
                    got++;
                end
            end
            tick;
        end
        out_ready = 1'b1;
        if (got < nwords) check("collect_timeout", 32'(got), 32'(nwords));
    endtask

    task automatic check_reads;
        check("rd_count", 32'(rd_q.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check("rd_addr", (rd_q.size() > i) ? rd_q[i] : 32'hFFFF, 32'(8 + i));
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = '0;
        rst = 1'b1; done = 1'b0; clock_count = 0; instr_cnt = 0; out_ready = 1'b1;
        tick; tick;
        rst = 1'b0;

        // Reset state
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_finished", 32'(finished), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_checksum", checksum, 32'd0);
        check("rst_ledr", 32'(LEDR), 32'd0);
        check("rst_rd_en", 32'(mem_rd_en), 32'd0);
        tick; tick;
        check("idle_no_pass", 32'(busy), 32'd0);

        // Basic read-out with latency and read timing
        load_results(19, 22, 43, 50);
        clock_count = 120; instr_cnt = 60; done = 1'b1;
        tick;
        clock_count = 999; instr_cnt = 777;
        check("trig_busy", 32'(busy), 32'd1);
        check("trig_rd_en", 32'(mem_rd_en), 32'd1);
        check("trig_addr", 32'(mem_addr), 32'd8);
        check("trig_no_valid", 32'(out_valid), 32'd0);
        collect(-1, 0, 4);
        check("basic_checksum", checksum, 32'd134);
        check("basic_ledr", 32'(LEDR), 32'd134);
        check("basic_cycles", cycles_lat, 32'd120);
        check("basic_instrs", instrs_lat, 32'd60);
        check("basic_finished", 32'(finished), 32'd1);
        check("basic_busy", 32'(busy), 32'd0);
        check_reads();
        done = 1'b0; tick; done = 1'b1; tick; tick;
        check("fin_ignore_done", 32'(finished), 32'd1);
        check("fin_no_rd", 32'(mem_rd_en), 32'd0);

        // Backpressure on word 22
        done = 1'b0;
        do_reset();
        tick;
        load_results(19, 22, 43, 50);
        clock_count = 5; instr_cnt = 6; done = 1'b1;
        tick;
        collect(1, 5, 4);
        check("bp_checksum", checksum, 32'd134);
        check("bp_finished", 32'(finished), 32'd1);
        check_reads();

        // Mid-pass reset after second handshake
        done = 1'b0;
        do_reset();
        tick;
        load_results(19, 22, 43, 50);
        done = 1'b1;
        tick;
        collect(-1, 0, 2);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        check("mid_busy", 32'(busy), 32'd0);
        check("mid_finished", 32'(finished), 32'd0);
        check("mid_valid", 32'(out_valid), 32'd0);
        check("mid_checksum", checksum, 32'd0);
        check("mid_data", out_data, 32'd0);
        check("mid_cycles", cycles_lat, 32'd0);
        check("mid_rd_en", 32'(mem_rd_en), 32'd0);
        done = 1'b0; tick;
        load_results(19, 22, 43, 50);
        done = 1'b1; tick;
        collect(-1, 0, 4);
        check("mid_rerun_checksum", checksum, 32'd134);
        check_reads();

        // done held high through reset release
        done = 1'b1;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            check("held_done_idle", 32'(busy), 32'd0);
            check("held_done_no_rd", 32'(mem_rd_en), 32'd0);
            tick;
        end
        load_results(19, 22, 43, 50);
        done = 1'b0; tick;
        done = 1'b1; tick;
        check("held_done_start", 32'(busy), 32'd1);
        collect(-1, 0, 4);
        check("held_done_checksum", checksum, 32'd134);

        // Checksum wrap-around
        done = 1'b0;
        do_reset();
        tick;
        load_results(32'hFFFFFFFF, 2, 0, 0);
        done = 1'b1; tick;
        collect(-1, 0, 4);
        check("wrap_checksum", checksum, 32'd1);
        check("wrap_ledr", 32'(LEDR), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
